// File: rtl/bus_arbiter_if.sv
// Bundle of per-core request ports and the shared bus port around bus_arbiter.
// Master-side vectors are flattened: master k occupies slice k.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32
);
  logic [N_MASTERS-1:0]          i_m_bus_en;
  logic [N_MASTERS-1:0]          i_m_wr_en;
  logic [N_MASTERS*XLEN-1:0]     i_m_wr_data;
  logic [N_MASTERS*XLEN-1:0]     i_m_addr;
  logic [N_MASTERS*(XLEN/8)-1:0] i_m_byte_en;
  logic [N_MASTERS-1:0]          i_m_lock;
  logic [N_MASTERS-1:0]          o_m_ack;
  logic [N_MASTERS-1:0]          o_m_err;
  logic [XLEN-1:0]               o_m_rd_data;
  logic                          o_bus_en;
  logic                          o_wr_en;
  logic [XLEN-1:0]               o_wr_data;
  logic [XLEN-1:0]               o_addr;
  logic [XLEN/8-1:0]             o_byte_en;
  logic                          i_ack;
  logic [XLEN-1:0]               i_rd_data;
  logic [N_MASTERS-1:0]          o_grant;

  // Arbiter view.
  modport slave (
    input  i_m_bus_en, i_m_wr_en, i_m_wr_data, i_m_addr, i_m_byte_en, i_m_lock,
    input  i_ack, i_rd_data,
    output o_m_ack, o_m_err, o_m_rd_data, o_bus_en, o_wr_en, o_wr_data,
    output o_addr, o_byte_en, o_grant
  );

  // Cores plus the downstream slave response.
  modport master (
    output i_m_bus_en, i_m_wr_en, i_m_wr_data, i_m_addr, i_m_byte_en, i_m_lock,
    output i_ack, i_rd_data,
    input  o_m_ack, o_m_err, o_m_rd_data, o_bus_en, o_wr_en, o_wr_data,
    input  o_addr, o_byte_en, o_grant
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus-master port between N_MASTERS cores,
// with bus locking for atomic sequences and an optional no-ack watchdog.
module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32,
  parameter int TIMEOUT   = 0
) (
  input logic          i_clk,
  input logic          i_rst,
  bus_arbiter_if.slave bus
);
  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int BE_W  = XLEN / 8;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MASTERS - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] cand_idx;
  int               cand_sum;
  logic             found;
  logic             own_en;
  logic             own_lock;
  logic             wd_fire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    wd_cnt_d    = '0;
    ptr_next    = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
    cand_idx    = '0;
    cand_sum    = 0;
    found       = 1'b0;
    own_en      = bus.i_m_bus_en[grant_idx_q];
    own_lock    = bus.i_m_lock[grant_idx_q];
    wd_fire     = 1'b0;

    bus.o_m_ack     = '0;
    bus.o_m_err     = '0;
    bus.o_m_rd_data = '0;
    bus.o_bus_en    = 1'b0;
    bus.o_wr_en     = 1'b0;
    bus.o_wr_data   = '0;
    bus.o_addr      = '0;
    bus.o_byte_en   = '0;
    bus.o_grant     = '0;

    // Reset silences every output, including an ack arriving mid-transfer.
    if (!i_rst) begin
      case (state_q)
        ST_IDLE: begin
          for (int i = 0; i < N_MASTERS; i++) begin
            cand_sum = int'(rr_ptr_q) + i;
            if (cand_sum >= N_MASTERS) cand_sum = cand_sum - N_MASTERS;
            cand_idx = IDX_W'(cand_sum);
            if (!found && bus.i_m_bus_en[cand_idx]) begin
              found       = 1'b1;
              grant_idx_d = cand_idx;
              state_d     = ST_GRANT;
            end
          end
        end

        ST_GRANT: begin
          for (int m = 0; m < N_MASTERS; m++) begin
            if (grant_idx_q == IDX_W'(m)) begin
              bus.o_wr_en   = bus.i_m_wr_en[m];
              bus.o_wr_data = bus.i_m_wr_data[m*XLEN +: XLEN];
              bus.o_addr    = bus.i_m_addr[m*XLEN +: XLEN];
              bus.o_byte_en = bus.i_m_byte_en[m*BE_W +: BE_W];
            end
          end
          bus.o_grant[grant_idx_q] = 1'b1;
          wd_fire = (TIMEOUT > 0) && own_en && !bus.i_ack && (wd_cnt_q == WD_LAST);

          if (wd_fire) begin
            // Forced error completion: bus dropped, lock ignored.
            bus.o_m_ack[grant_idx_q] = 1'b1;
            bus.o_m_err[grant_idx_q] = 1'b1;
            state_d  = ST_IDLE;
            rr_ptr_d = ptr_next;
          end else begin
            bus.o_bus_en             = own_en;
            bus.o_m_rd_data          = bus.i_rd_data;
            bus.o_m_ack[grant_idx_q] = bus.i_ack & own_en;
            if (own_en && bus.i_ack) begin
              if (!own_lock) begin
                state_d  = ST_IDLE;
                rr_ptr_d = ptr_next;
              end
            end else if (own_en) begin
              wd_cnt_d = wd_cnt_q + 1'b1;
            end else if (!own_lock) begin
              state_d  = ST_IDLE;
              rr_ptr_d = ptr_next;
            end else begin
              wd_cnt_d = wd_cnt_q;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter with three masters and an 8-cycle watchdog.
// Each cycle's expected outputs are queued with the stimulus and compared per scenario.
module tb_bus_arbiter;
  typedef struct packed {
    logic [2:0]  grant;
    logic        bus_en;
    logic        wr;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;
  out_t exp_q[$];
  out_t obs_q[$];

  bus_arbiter_if #(.N_MASTERS(3), .XLEN(32)) bif ();

  bus_arbiter #(.N_MASTERS(3), .XLEN(32), .TIMEOUT(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Expected outputs; shared-bus fields follow the one-hot owner in g.
  function automatic out_t ex(input logic [2:0] g, input logic be, input logic wr,
                              input logic [2:0] a, input logic [2:0] er,
                              input logic [31:0] rd);
    out_t e;
    e        = '0;
    e.grant  = g;
    e.bus_en = be;
    e.wr     = wr;
    e.ack    = a;
    e.err    = er;
    e.rd     = rd;
    if (g[0]) begin e.addr = 32'h0000_0100; e.wdata = 32'hA000_0000; e.ben = 4'hF; end
    if (g[1]) begin e.addr = 32'h0000_0200; e.wdata = 32'hA000_0001; e.ben = 4'h3; end
    if (g[2]) begin e.addr = 32'h0000_0300; e.wdata = 32'hA000_0002; e.ben = 4'hC; end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [2:0] en, input logic [2:0] wr,
                       input logic [2:0] lk, input logic a, input logic [31:0] rd,
                       input out_t e);
    out_t o;
    @(posedge clk);
    #1;
    rst            = r;
    bif.i_m_bus_en = en;
    bif.i_m_wr_en  = wr;
    bif.i_m_lock   = lk;
    bif.i_ack      = a;
    bif.i_rd_data  = rd;
    exp_q.push_back(e);
    @(negedge clk);
    o.grant  = bif.o_grant;
    o.bus_en = bif.o_bus_en;
    o.wr     = bif.o_wr_en;
    o.ack    = bif.o_m_ack;
    o.err    = bif.o_m_err;
    o.rd     = bif.o_m_rd_data;
    o.addr   = bif.o_addr;
    o.wdata  = bif.o_wr_data;
    o.ben    = bif.o_byte_en;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    out_t e, o;
    int c = 0;
    drive(1'b1, 3'b111, 3'b111, 3'b111, 1'b1, 32'hFFFF_FFFF, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 32'h1234_5678, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL reset cyc%0d: got %h want %h", c, o, e); end
      c++;
    end
  endtask

  task automatic test_single_read();
    out_t e, o;
    int c = 0;
    drive(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b001, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b001, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 32'hDEAD_BEEF,
          ex(3'b001, 1, 0, 3'b001, 3'b000, 32'hDEAD_BEEF));
    drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    // Pointer now at 1: master 1 beats master 0.
    drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b010, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b1, 32'h11, ex(3'b010, 1, 0, 3'b010, 3'b000, 32'h11));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL single_read cyc%0d: got %h want %h", c, o, e); end
      c++;
    end
  endtask

  task automatic test_contention();
    out_t e, o;
    int c = 0;
    logic [2:0] oh;
    drive(1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    for (int i = 0; i < 12; i++) begin
      oh = 3'(1 << ((i / 2) % 3));
      if (i % 2 == 0)
        drive(1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 32'hC000_0000 + 32'(i),
              ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
      else
        drive(1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 32'hC000_0000 + 32'(i),
              ex(oh, 1, 0, oh, 3'b000, 32'hC000_0000 + 32'(i)));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL contention cyc%0d: got %h want %h", c, o, e); end
      c++;
    end
  endtask

  task automatic test_lock();
    out_t e, o;
    int c = 0;
    drive(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b010, 3'b000, 3'b010, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b000, 3'b010, 1'b0, 32'h0, ex(3'b010, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b000, 3'b010, 1'b1, 32'h5A5A_5A5A,
          ex(3'b010, 1, 0, 3'b010, 3'b000, 32'h5A5A_5A5A));
    drive(1'b0, 3'b011, 3'b010, 3'b010, 1'b0, 32'h0, ex(3'b010, 1, 1, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b010, 3'b010, 1'b1, 32'h0, ex(3'b010, 1, 1, 3'b010, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b010, 1'b0, 32'h0, ex(3'b010, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b010, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b001, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 32'h77, ex(3'b001, 1, 0, 3'b001, 3'b000, 32'h77));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL lock cyc%0d: got %h want %h", c, o, e); end
      c++;
    end
  endtask

  task automatic test_watchdog();
    out_t e, o;
    int c = 0;
    drive(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'hBAD, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    for (int i = 0; i < 7; i++)
      drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b0, 32'hBAD, ex(3'b001, 1, 0, 3'b000, 3'b000, 32'hBAD));
    drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b0, 32'hBAD, ex(3'b001, 0, 0, 3'b001, 3'b001, 0));
    // Late ack lands in IDLE and is dropped.
    drive(1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 32'hBAD, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'hBAD, ex(3'b010, 1, 0, 3'b000, 3'b000, 32'hBAD));
    drive(1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 32'h22, ex(3'b010, 1, 0, 3'b010, 3'b000, 32'h22));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL watchdog cyc%0d: got %h want %h", c, o, e); end
      c++;
    end
  endtask

  task automatic test_reset_mid();
    out_t e, o;
    int c = 0;
    drive(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b010, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b1, 3'b011, 3'b000, 3'b000, 1'b1, 32'h1234, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b001, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b011, 3'b000, 3'b000, 1'b1, 32'h4321, ex(3'b001, 1, 0, 3'b001, 3'b000, 32'h4321));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL reset_mid cyc%0d: got %h want %h", c, o, e); end
      c++;
    end
  endtask

  task automatic test_withdraw();
    out_t e, o;
    int c = 0;
    drive(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b010, 1, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 32'h99, ex(3'b010, 0, 0, 3'b000, 3'b000, 32'h99));
    drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 32'h99, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    // Pointer advanced past master 1, so master 2 wins.
    drive(1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b000, 0, 0, 3'b000, 3'b000, 0));
    drive(1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 32'h0, ex(3'b100, 1, 0, 3'b000, 3'b000, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL withdraw cyc%0d: got %h want %h", c, o, e); end
      c++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bif.i_m_bus_en  = '0;
    bif.i_m_wr_en   = '0;
    bif.i_m_lock    = '0;
    bif.i_ack       = 1'b0;
    bif.i_rd_data   = '0;
    bif.i_m_addr    = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    bif.i_m_wr_data = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    bif.i_m_byte_en = {4'hC, 4'h3, 4'hF};
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_watchdog();
    test_reset_mid();
    test_withdraw();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Round-robin arbiter that shares one system bus-master port between `N_MASTERS` per-core bus-master ports.
- Each core's top-level wrapper exposes a single bus master (instruction and data traffic already merged). This block sits between those wrappers and the memory/peripheral interconnect in multi-core builds.
- Supports bus locking, so a core's atomic sequence (LR/SC, AMO read-modify-write) is not interleaved with other cores.
- Has an optional no-ack watchdog.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of requesters, range 2..8.
- `XLEN`, default 32: address and data width.
- `TIMEOUT`, default 0: cycles to wait for `i_ack` before forcing an error completion. 0 disables the watchdog.

Ports (master-side vectors are flattened; master k occupies slice k):
- `i_clk` in 1: clock. One clock; reset is synchronous and active-high.
- `i_rst` in 1: synchronous active-high reset.
- `i_m_bus_en` in N_MASTERS: request/transfer valid per master.
- `i_m_wr_en` in N_MASTERS: write (1) / read (0).
- `i_m_wr_data` in N_MASTERS*XLEN: write data.
- `i_m_addr` in N_MASTERS*XLEN: address.
- `i_m_byte_en` in N_MASTERS*(XLEN/8): byte enables.
- `i_m_lock` in N_MASTERS: keep grant after the current transfer completes.
- `o_m_ack` out N_MASTERS: transfer complete, one-hot or zero.
- `o_m_err` out N_MASTERS: completion was forced by the watchdog; only valid together with `o_m_ack`.
- `o_m_rd_data` out XLEN: read data, broadcast to all masters; valid only with that master's ack.
- `o_bus_en`, `o_wr_en`, `o_wr_data`, `o_addr`, `o_byte_en` out: shared bus master port, same widths as one master slice.
- `i_ack` in 1, `i_rd_data` in XLEN: shared bus response.
- `o_grant` out N_MASTERS: current owner, one-hot or zero (debug/perf).

## Operation
- State register: IDLE or GRANT. Registers: `grant_idx`, `rr_ptr`, watchdog counter `wd_cnt`.
- **IDLE**
  - The winner is the first asserted `i_m_bus_en[k]` searching k = rr_ptr, rr_ptr+1, … modulo N_MASTERS.
  - On a winner: register `grant_idx` and go to GRANT. No transfer is issued in the IDLE cycle.
- **GRANT**
  - Shared outputs are combinationally muxed from master `grant_idx`, with `o_bus_en = i_m_bus_en[grant_idx]`.
  - `o_m_ack[grant_idx] = i_ack & o_bus_en`. All other masters' acks are 0.
  - `o_m_rd_data = i_rd_data`.
- **Completion** (ack with `o_bus_en` high):
  - If `i_m_lock[grant_idx]` is 0: go to IDLE and set `rr_ptr = grant_idx+1` (wraps to 0).
  - If lock is 1: stay in GRANT and keep `rr_ptr`.
- **Lock release without a transfer:** in GRANT with `i_m_bus_en[grant_idx]` = 0 and `i_m_lock[grant_idx]` = 0, go to IDLE and advance `rr_ptr`. This also covers a master that withdraws.
- **Master protocol:**
  - Hold `bus_en` and all request fields stable until ack.
  - Deassert `bus_en` in the cycle after ack unless issuing a new transfer.
  - A locked master may issue further transfers, each completed by its own ack.
- **Ignored inputs:** `i_ack` outside GRANT, or with `o_bus_en` low, is ignored.
- **Watchdog** (TIMEOUT > 0):
  - `wd_cnt` counts cycles in GRANT with `o_bus_en` = 1 and `i_ack` = 0. It clears on ack and on leaving GRANT.
  - When `wd_cnt` reaches TIMEOUT-1 with no ack, the block drives `o_m_ack` and `o_m_err` for the owner for 1 cycle and `o_m_rd_data` = 0.
  - It then returns to IDLE regardless of lock, advancing `rr_ptr`.
  - `o_bus_en` goes low in that cycle. A late `i_ack` is dropped.
- **Reset:** state IDLE, `rr_ptr` = 0, `grant_idx` = 0, `wd_cnt` = 0. All outputs are 0 during and after reset until the first grant: `o_bus_en`, `o_wr_en`, `o_wr_data`, `o_addr`, `o_byte_en`, `o_m_ack`, `o_m_err`, `o_m_rd_data`, `o_grant`.
- **Reset mid-transfer:** the transfer is abandoned. No ack is forwarded in the reset cycle.

## Timing
- Request seen at cycle t in IDLE: `o_grant` and `o_bus_en` are valid at t+1.
- Ack latency to the master equals the slave's `i_ack` latency plus 0 cycles (combinational pass-through).
- Unlocked back-to-back transfers from the same master cost 1 IDLE cycle between the ack and the next `o_bus_en`.
- Under a locked grant the next transfer can start the cycle after the ack, with no IDLE cycle.
- No outputs are registered except `o_grant`, which is decoded from state and `grant_idx`.
- Fairness: with all masters requesting continuously and unlocked, each master gets at most 1 transfer per N_MASTERS grants.

## Test plan
- **Single master, read:** master 0 `bus_en` with addr 0x100 at t0; slave acks at t0+3 with rd_data 0xDEADBEEF. Required: `o_bus_en` rises at t0+1; `o_m_ack` = 01 at t0+3 with `o_m_rd_data` = 0xDEADBEEF; state IDLE at t0+4; `rr_ptr` = 1.
- **Contention, round-robin (N=3):** all three request every transfer with 1-cycle slave ack from reset. Required: grant order 0,1,2,0,1,2; no master is granted twice in a row.
- **Lock:** master 1 holds lock across a read at 0x200 and a write at 0x200 while master 0 requests continuously. Required: master 0 is not granted until the cycle after master 1 drops lock with `bus_en` low; the second transfer starts the cycle after the first ack.
- **Watchdog (TIMEOUT=8):** the slave never acks master 0. Required: at the 8th GRANT cycle with `bus_en` high, `o_m_ack[0]` = `o_m_err[0]` = 1 and `o_m_rd_data` = 0; the next cycle is IDLE; master 1's pending request is granted after that.
- **Reset mid-transfer:** assert `i_rst` 1 cycle while master 1 is granted and waiting; the slave acks in the reset cycle. Required: no `o_m_ack`; all outputs 0; `rr_ptr` = 0; master 0 wins the next contention.
- **Withdrawal and stray ack:** the granted master drops `bus_en` without lock before ack; `i_ack` pulses in IDLE. Required: return to IDLE, pointer advances, no ack is forwarded.
